// File: rtl/prog_loader.sv
// Boot-time program memory loader: parses a framed byte stream (16-bit length, big-endian
// words, XOR checksum), writes words at addresses 0..N-1 and holds the CPU in reset until it checks out.
module prog_loader #(
    parameter int BIT_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH = 6,
    parameter int DEPTH          = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [BIT_WIDTH-1:0]      mem_data,
    output logic                      mem_wren,
    output logic                      cpu_rst,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int BYTES = BIT_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t                 state_q;
    state_t                 state_nxt;
    logic [15:0]            len_q;
    logic [15:0]            word_idx_q;
    logic [BCW-1:0]         byte_cnt_q;
    logic [7:0]             csum_q;
    logic [BIT_WIDTH-1:0]   word_q;

    logic                   accept;
    logic [15:0]            len_full;
    logic [15:0]            idx_inc;
    logic [BIT_WIDTH-1:0]   word_nxt;
    logic                   last_byte;

    always_comb begin
        accept    = in_valid && in_ready;
        len_full  = {len_q[15:8], in_data};
        idx_inc   = word_idx_q + 16'd1;
        // shift in from the LSB end so the first byte of a word ends up in the MSBs
        word_nxt  = BIT_WIDTH'({word_q, in_data});
        last_byte = (byte_cnt_q == BCW'(BYTES - 1));
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) state_nxt = LEN_HI;
            end
            LEN_HI: begin
                if (accept) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if (len_full > 16'(DEPTH))  state_nxt = ERR;
                    else if (len_full == 16'd0) state_nxt = CSUM;
                    else                        state_nxt = DATA;
                end
            end
            DATA: begin
                if (accept && last_byte) state_nxt = WRITE;
            end
            WRITE: begin
                state_nxt = (idx_inc == len_q) ? CSUM : DATA;
            end
            CSUM: begin
                if (accept) state_nxt = (in_data == csum_q) ? DONE : ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready   <= 1'b0;
            mem_wren   <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            cpu_rst    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            word_q     <= '0;
        end else begin
            in_ready <= (state_nxt inside {LEN_HI, LEN_LO, DATA, CSUM});
            mem_wren <= (state_nxt == WRITE);
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        cpu_rst    <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        len_q      <= '0;
                        word_idx_q <= '0;
                        byte_cnt_q <= '0;
                        csum_q     <= '0;
                    end
                end
                LEN_HI: begin
                    if (accept) len_q[15:8] <= in_data;
                end
                LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= in_data;
                        if (len_full > 16'(DEPTH)) begin
                            err  <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        word_q <= word_nxt;
                        csum_q <= csum_q ^ in_data;
                        if (last_byte) begin
                            // present the completed word together with the write strobe
                            byte_cnt_q <= '0;
                            mem_addr   <= word_idx_q[MEM_ADDR_WIDTH-1:0];
                            mem_data   <= word_nxt;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BCW'(1);
                        end
                    end
                end
                WRITE: begin
                    word_idx_q <= idx_inc;
                end
                CSUM: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (in_data == csum_q) begin
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed loads, bad checksum, oversize length, empty load,
// gapped 64-word load and reset in the middle of a load.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [5:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int wren_cnt  = 0;
    int last_addr = -1;
    logic [31:0] tb_mem [64];
    logic [31:0] img [64];

    always #5 clk = ~clk;

    prog_loader #(.BIT_WIDTH(32), .MEM_ADDR_WIDTH(6), .DEPTH(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wren (mem_wren),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // program memory beside the write port
    always @(posedge clk) begin
        if (mem_wren === 1'b1) begin
            tb_mem[mem_addr] <= mem_data;
            wren_cnt         <= wren_cnt + 1;
            last_addr        <= int'(mem_addr);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int waited = 0;
        if (gap && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL byte_accept_timeout: observed in_ready=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    function automatic logic [7:0] img_csum(input int n);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < n; i++)
            c = c ^ img[i][31:24] ^ img[i][23:16] ^ img[i][15:8] ^ img[i][7:0];
        return c;
    endfunction

    initial begin
        int base;
        logic [31:0] keep1;
        logic [31:0] keep3;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_wren", mem_wren, 0);
        chk("rst_flags", {cpu_rst, busy, done, err}, 4'b0000);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 0);

        // good two-word load; XOR of the eight data bytes is 0x21
        img[0] = 32'h24080005;
        img[1] = 32'h00000008;
        base = wren_cnt;
        do_start();
        chk("t1_start_flags", {cpu_rst, busy, done, err, in_ready}, 5'b11001);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(img[0], 1'b0);
        chk("t1_w0_wren", mem_wren, 1);
        chk("t1_w0_addr", mem_addr, 0);
        chk("t1_w0_data", mem_data, 32'h24080005);
        chk("t1_write_in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("t1_wren_one_cycle", mem_wren, 0);
        send_word(img[1], 1'b0);
        send_byte(8'h21, 1'b0);
        chk("t1_end_flags", {cpu_rst, busy, done, err}, 4'b0010);
        chk("t1_wren_count", wren_cnt - base, 2);
        chk("t1_mem0", tb_mem[0], 32'h24080005);
        chk("t1_mem1", tb_mem[1], 32'h00000008);
        @(posedge clk); #1;
        chk("t1_hold", {mem_addr, mem_data}, {6'd1, 32'h00000008});

        // same stream, wrong checksum; stray start mid-load must be ignored
        base = wren_cnt;
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        do_start();
        chk("t2_busy_start_ignored", {busy, in_ready}, 2'b11);
        send_word(img[0], 1'b0);
        send_word(img[1], 1'b0);
        send_byte(8'h28, 1'b0);
        chk("t2_end_flags", {cpu_rst, busy, done, err}, 4'b1001);
        chk("t2_wren_count", wren_cnt - base, 2);
        chk("t2_last_addr", last_addr, 1);
        chk("t2_mem1", tb_mem[1], 32'h00000008);

        // oversize length 65 errors right after the low length byte
        base = wren_cnt;
        do_start();
        chk("t3_err_cleared", {cpu_rst, err}, 2'b10);
        send_byte(8'h00, 1'b0);
        send_byte(8'h41, 1'b0);
        chk("t3_err_now", {busy, err, in_ready}, 3'b010);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_no_write", wren_cnt - base, 0);
        chk("t3_cpu_rst_held", cpu_rst, 1);

        // empty load
        base = wren_cnt;
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("t4_csum_ready", in_ready, 1);
        send_byte(8'h00, 1'b0);
        chk("t4_end_flags", {cpu_rst, busy, done, err}, 4'b0010);
        chk("t4_no_write", wren_cnt - base, 0);

        // full-depth load with random source gaps
        for (int i = 0; i < 64; i++)
            img[i] = {8'(i), ~8'(i), 8'(i * 7 + 3), 8'hC3 ^ 8'(i)};
        keep1 = img[1];
        keep3 = img[3];
        base = wren_cnt;
        do_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h40, 1'b1);
        for (int i = 0; i < 64; i++)
            send_word(img[i], 1'b1);
        send_byte(img_csum(64), 1'b1);
        chk("t5_done", {cpu_rst, busy, done, err}, 4'b0010);
        chk("t5_wren_count", wren_cnt - base, 64);
        chk("t5_last_addr", last_addr, 63);
        for (int i = 0; i < 64; i++)
            chk($sformatf("t5_mem%0d", i), tb_mem[i], img[i]);

        // reset in the middle of word 1, then a fresh good load
        img[0] = 32'hDEADBEEF;
        img[1] = 32'h01234567;
        img[2] = 32'hCAFEF00D;
        base = wren_cnt;
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_word(img[0], 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h23, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_rst_flags", {cpu_rst, busy, done, err, in_ready, mem_wren}, 6'b000000);
        chk("t6_rst_addr", mem_addr, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("t6_abort_writes", wren_cnt - base, 1);
        chk("t6_abort_mem1", tb_mem[1], keep1);
        base = wren_cnt;
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        for (int i = 0; i < 3; i++)
            send_word(img[i], 1'b0);
        send_byte(img_csum(3), 1'b0);
        chk("t6_done", {cpu_rst, busy, done, err}, 4'b0010);
        chk("t6_wren_count", wren_cnt - base, 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t6_mem%0d", i), tb_mem[i], img[i]);
        chk("t6_mem3_kept", tb_mem[3], keep3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
